// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: SPI-commanded trigger/capture into an external sample
// buffer, followed by SPI readout of the captured samples.
module adc_capture_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        adc_sample,
  input  logic              adc_valid,
  input  logic [1:0]        ext_trig,
  input  logic [7:0]        rx_byte,
  input  logic              rx_flag,
  output logic [7:0]        tx_byte,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [7:0]        buf_rdata,
  output logic              busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_READOUT = 3'd4;

  localparam logic [7:0] OP_ABORT     = 8'h00;
  localparam logic [7:0] OP_SET_LEVEL = 8'h01;
  localparam logic [7:0] OP_SET_LEN   = 8'h02;
  localparam logic [7:0] OP_SET_MODE  = 8'h03;
  localparam logic [7:0] OP_ARM       = 8'h04;
  localparam logic [7:0] OP_READ      = 8'h05;

  // Index of the last sample: (len+1)*4-1, with the length capped at the buffer depth.
  function automatic logic [ADDR_W:0] f_last(input logic [7:0] len);
    int unsigned raw;
    raw = (int'(len) + 32'd1) * 32'd4;
    if (raw > (32'd1 << ADDR_W)) begin
      raw = 32'd1 << ADDR_W;
    end else begin
      raw = raw;
    end
    return (ADDR_W+1)'(raw - 32'd1);
  endfunction

  logic [2:0]      r_state, w_state;
  logic [7:0]      r_level, w_level;
  logic [7:0]      r_len, w_len;
  logic [7:0]      r_mode, w_mode;
  logic            r_done, w_done;
  logic            r_pend, w_pend;
  logic [1:0]      r_pend_op, w_pend_op;
  logic [ADDR_W:0] r_count, w_count;
  logic [ADDR_W:0] r_index, w_index;
  logic            r_prev_valid, w_prev_valid;
  logic [7:0]      r_prev_sample, w_prev_sample;
  logic            r_edge_seen, w_edge_seen;
  logic [1:0]      r_trig_q;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;
  logic [ADDR_W-1:0] w_raddr;
  logic [7:0]        w_tx;
  logic              w_busy;
  logic [ADDR_W:0]   w_last;
  logic              w_cfg_ok;
  logic              w_edge;
  logic              w_hit;

  assign w_last   = f_last(r_len);
  assign w_cfg_ok = (r_state == S_IDLE) || (r_state == S_DONE);
  // mode 2 watches ext_trig[0], mode 3 watches ext_trig[1]
  assign w_edge   = ext_trig[r_mode[0]] & ~r_trig_q[r_mode[0]];
  assign w_hit    = (r_mode[1:0] == 2'd1)
                  ? (r_prev_valid && (r_prev_sample < r_level) && (adc_sample >= r_level))
                  : (r_mode[1] && (w_edge || r_edge_seen));
  assign w_tx     = (w_state == S_READOUT) ? buf_rdata : {w_done, 4'b0000, w_state};
  assign w_busy   = (w_state == S_ARMED) || (w_state == S_CAPTURE);

  // Next-state logic: sample path first, then SPI commands which take precedence.
  always_comb begin
    w_state       = r_state;
    w_level       = r_level;
    w_len         = r_len;
    w_mode        = r_mode;
    w_done        = r_done;
    w_pend        = r_pend;
    w_pend_op     = r_pend_op;
    w_count       = r_count;
    w_index       = r_index;
    w_prev_valid  = r_prev_valid;
    w_prev_sample = r_prev_sample;
    w_edge_seen   = r_edge_seen;
    w_we          = 1'b0;
    w_waddr       = buf_waddr;
    w_wdata       = buf_wdata;
    w_raddr       = buf_raddr;

    case (r_state)
      S_ARMED: begin
        if (adc_valid && w_hit) begin
          w_we    = 1'b1;
          w_waddr = {ADDR_W{1'b0}};
          w_wdata = adc_sample;
          w_count = {{ADDR_W{1'b0}}, 1'b1};
          w_state = S_CAPTURE;
        end else begin
          if (adc_valid) begin
            w_prev_valid  = 1'b1;
            w_prev_sample = adc_sample;
          end else begin
            w_prev_valid  = r_prev_valid;
          end
          if (w_edge) begin
            w_edge_seen = 1'b1;
          end else begin
            w_edge_seen = r_edge_seen;
          end
        end
      end
      S_CAPTURE: begin
        if (adc_valid) begin
          w_we    = 1'b1;
          w_waddr = r_count[ADDR_W-1:0];
          w_wdata = adc_sample;
          w_count = r_count + {{ADDR_W{1'b0}}, 1'b1};
          if (r_count == w_last) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = S_CAPTURE;
          end
        end else begin
          w_count = r_count;
        end
      end
      S_READOUT: begin
        if (rx_flag) begin
          if (r_index == w_last) begin
            w_state = S_DONE;
          end else begin
            w_index = r_index + {{ADDR_W{1'b0}}, 1'b1};
            w_raddr = w_index[ADDR_W-1:0];
          end
        end else begin
          w_raddr = r_index[ADDR_W-1:0];
        end
      end
      default: begin
        w_state = r_state;
      end
    endcase

    if (rx_flag && (r_state != S_READOUT)) begin
      if (r_pend) begin
        // payload byte: any value, 0x00 included, is data here
        w_pend = 1'b0;
        if (w_cfg_ok) begin
          case (r_pend_op)
            2'd1:    w_level = rx_byte;
            2'd2:    w_len   = rx_byte;
            2'd3:    w_mode  = rx_byte;
            default: w_level = r_level;
          endcase
        end else begin
          w_level = r_level;
        end
      end else begin
        case (rx_byte)
          OP_ABORT: begin
            w_state = S_IDLE;
            w_done  = 1'b0;
            w_we    = 1'b0;
            w_waddr = buf_waddr;
            w_wdata = buf_wdata;
          end
          OP_SET_LEVEL, OP_SET_LEN, OP_SET_MODE: begin
            w_pend    = 1'b1;
            w_pend_op = rx_byte[1:0];
          end
          OP_ARM: begin
            if (w_cfg_ok) begin
              w_done       = 1'b0;
              w_count      = {(ADDR_W+1){1'b0}};
              w_prev_valid = 1'b0;
              w_edge_seen  = 1'b0;
              w_state      = (r_mode[1:0] == 2'd0) ? S_CAPTURE : S_ARMED;
            end else begin
              w_done = r_done;
            end
          end
          OP_READ: begin
            if (r_state == S_DONE) begin
              w_state = S_READOUT;
              w_index = {(ADDR_W+1){1'b0}};
              w_raddr = {ADDR_W{1'b0}};
            end else begin
              w_index = r_index;
            end
          end
          default: begin
            w_pend = r_pend;
          end
        endcase
      end
    end else begin
      w_pend = r_pend;
    end
  end

  // State and registered outputs; reset overrides every same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_level       <= 8'h80;
      r_len         <= 8'hFF;
      r_mode        <= 8'h00;
      r_done        <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_op     <= 2'd0;
      r_count       <= {(ADDR_W+1){1'b0}};
      r_index       <= {(ADDR_W+1){1'b0}};
      r_prev_valid  <= 1'b0;
      r_prev_sample <= 8'h00;
      r_edge_seen   <= 1'b0;
      r_trig_q      <= 2'b00;
      buf_we        <= 1'b0;
      buf_waddr     <= {ADDR_W{1'b0}};
      buf_wdata     <= 8'h00;
      buf_raddr     <= {ADDR_W{1'b0}};
      tx_byte       <= 8'h00;
      busy          <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_level       <= w_level;
      r_len         <= w_len;
      r_mode        <= w_mode;
      r_done        <= w_done;
      r_pend        <= w_pend;
      r_pend_op     <= w_pend_op;
      r_count       <= w_count;
      r_index       <= w_index;
      r_prev_valid  <= w_prev_valid;
      r_prev_sample <= w_prev_sample;
      r_edge_seen   <= w_edge_seen;
      r_trig_q      <= ext_trig;
      buf_we        <= w_we;
      buf_waddr     <= w_waddr;
      buf_wdata     <= w_wdata;
      buf_raddr     <= w_raddr;
      tx_byte       <= w_tx;
      busy          <= w_busy;
    end
  end

endmodule
